// File: rtl/piano_pkg.sv
// ---------------------------------------------------------------------------
// piano_pkg
// Shared definitions for the piano key bus: note index and duration widths,
// default recorder depth, the note-index constants used by the song players,
// the keypad and the tone generator, and the recorded event record.
// ---------------------------------------------------------------------------
package piano_pkg;

  // Bus and recorder defaults
  localparam int KEY_W     = 4;
  localparam int DUR_W     = 26;
  localparam int REC_DEPTH = 32;

  typedef logic [KEY_W-1:0] note_t;

  // Chromatic note indices within one octave, plus the first note above it
  localparam note_t NOTE_C  = 4'd0;
  localparam note_t NOTE_CS = 4'd1;
  localparam note_t NOTE_D  = 4'd2;
  localparam note_t NOTE_DS = 4'd3;
  localparam note_t NOTE_E  = 4'd4;
  localparam note_t NOTE_F  = 4'd5;
  localparam note_t NOTE_FS = 4'd6;
  localparam note_t NOTE_G  = 4'd7;
  localparam note_t NOTE_GS = 4'd8;
  localparam note_t NOTE_A  = 4'd9;
  localparam note_t NOTE_AS = 4'd10;
  localparam note_t NOTE_B  = 4'd11;
  localparam note_t NOTE_C5 = 4'd12;

  // One recorded note: which key and how many clk cycles it was held
  typedef struct packed {
    note_t            key;
    logic [DUR_W-1:0] dur;
  } key_event_t;

  // Packs a key/duration pair into an event record
  function automatic key_event_t make_event(input note_t key, input logic [DUR_W-1:0] dur);
    key_event_t ev;
    ev.key = key;
    ev.dur = dur;
    return ev;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// ---------------------------------------------------------------------------
// key_event_fifo
// Synchronous FIFO of DEPTH words of W bits holding recorded note events.
// Reads have one cycle of latency: a pop accepted on one edge presents the
// oldest word on rd_data with rd_valid high for the following cycle.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-low reset (control state only)
//   clear     synchronous flush of pointers and count; beats push and pop
//   push      write request for push_data
//   push_data word to store
//   pop       read request; ignored while empty
//   rd_valid  one-cycle strobe qualifying rd_data
//   rd_data   popped word
//   count     stored words, 0..DEPTH
//   full      count == DEPTH
//   empty     count == 0
//   drop      a push was refused because the FIFO was full with no pop
// ---------------------------------------------------------------------------
module key_event_fifo #(
  parameter int W     = 30,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic          rd_valid,
  output logic [W-1:0]  rd_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          drop
);

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_do;
  logic          push_do;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  // A pop in the same cycle frees a slot, so a push while full is still
  // accepted when it is paired with a pop.
  assign pop_do  = pop & ~empty & ~clear;
  assign push_do = push & (~full | pop_do) & ~clear;
  assign drop    = push & full & ~pop_do & ~clear;

  // Event storage; left unreset since count decides what is meaningful
  always_ff @(posedge clk) begin
    if (push_do) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and the registered read port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop_do;
      if (push_do) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop_do) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PTR_ONE;
      end
      case ({push_do, pop_do})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_recorder.sv
// ---------------------------------------------------------------------------
// key_recorder
// Listens on the key_on/key note bus, times every note press in clk cycles
// and stores {key, duration} events in an on-chip FIFO for later readback.
// It only observes the bus and never influences the tone generator.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   key_on    note gate, synchronous to clk
//   key       note index, valid while key_on is high
//   rec_en    arms capture; looked at only when a press starts
//   clear     synchronous flush of FIFO, count and overflow; aborts a press
//   rd_en     pop request, one event per cycle
//   rd_valid  one-cycle strobe qualifying rd_key / rd_dur
//   rd_key    popped note index
//   rd_dur    popped duration in clk cycles
//   count     stored events, 0..DEPTH
//   full      count == DEPTH
//   overflow  sticky: an event was lost because the FIFO was full
//   busy      a press is currently being timed
// ---------------------------------------------------------------------------
module key_recorder
  import piano_pkg::*;
#(
  parameter int KEY_W = piano_pkg::KEY_W,
  parameter int DUR_W = piano_pkg::DUR_W,
  parameter int DEPTH = piano_pkg::REC_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_on,
  input  logic [KEY_W-1:0] key,
  input  logic             rec_en,
  input  logic             clear,
  input  logic             rd_en,
  output logic             rd_valid,
  output logic [KEY_W-1:0] rd_key,
  output logic [DUR_W-1:0] rd_dur,
  output logic [AW:0]      count,
  output logic             full,
  output logic             overflow,
  output logic             busy
);

  localparam int               EW      = KEY_W + DUR_W;
  localparam logic [DUR_W-1:0] DUR_ONE = DUR_W'(1);
  localparam logic [DUR_W-1:0] DUR_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRESS  = 2'd1,
    COMMIT = 2'd2
  } rec_state_t;

  rec_state_t       state;
  logic             key_on_q;
  logic             rise;
  logic             fall;
  logic [KEY_W-1:0] cur_key;
  logic [DUR_W-1:0] dur;
  logic             push;
  logic [EW-1:0]    push_data;
  logic [EW-1:0]    rd_data;
  logic             fifo_empty;
  logic             fifo_drop;

  // Registered gate used for press/release edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_on_q <= 1'b0;
    end else begin
      key_on_q <= key_on;
    end
  end

  assign rise = key_on & ~key_on_q;
  assign fall = ~key_on & key_on_q;

  // An event is produced when the key changes under a held gate (legato) or
  // one cycle after release, once the final duration has settled.
  assign push      = ((state == PRESS) && key_on && (key != cur_key)) || (state == COMMIT);
  assign push_data = {cur_key, dur};

  // Press timing FSM. The duration counts every edge at which key_on is
  // sampled high for the current note, so the starting edge already counts
  // as 1. A clear drops whatever press is in flight; since key_on_q keeps
  // tracking the bus, a key held through the clear needs a fresh rise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      cur_key <= '0;
      dur     <= '0;
    end else if (clear) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rise && rec_en) begin
            state   <= PRESS;
            busy    <= 1'b1;
            cur_key <= key;
            dur     <= DUR_ONE;
          end
        end
        PRESS: begin
          if (fall) begin
            state <= COMMIT;
            busy  <= 1'b0;
          end else if (key != cur_key) begin
            cur_key <= key;
            dur     <= DUR_ONE;
          end else if (dur != DUR_MAX) begin
            dur <= dur + DUR_ONE;
          end
        end
        COMMIT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky record of any event lost to a full FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (clear) begin
      overflow <= 1'b0;
    end else if (fifo_drop) begin
      overflow <= 1'b1;
    end
  end

  key_event_fifo #(
    .W     (EW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (push),
    .push_data (push_data),
    .pop       (rd_en),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .count     (count),
    .full      (full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  assign rd_key = rd_data[EW-1:DUR_W];
  assign rd_dur = rd_data[DUR_W-1:0];

  // Occupancy is also visible through count; empty is only used internally
  logic unused_empty;
  assign unused_empty = fifo_empty;

endmodule

// File: tb/tb_key_recorder.sv
// ---------------------------------------------------------------------------
// tb_key_recorder
// Self-checking bench for key_recorder. Expected events are queued when a
// note is played and compared as the DUT pops them out.
// ---------------------------------------------------------------------------
module tb_key_recorder;
  import piano_pkg::*;

  localparam int KW    = 4;
  localparam int DW    = 26;
  localparam int DEP   = 32;
  localparam int AWID  = 5;
  localparam int SDW   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            key_on;
  logic [KW-1:0]   key;
  logic            rec_en;
  logic            clear;
  logic            rd_en;
  logic            rd_valid;
  logic [KW-1:0]   rd_key;
  logic [DW-1:0]   rd_dur;
  logic [AWID:0]   count;
  logic            full;
  logic            overflow;
  logic            busy;

  logic            sat_key_on;
  logic [KW-1:0]   sat_key;
  logic            sat_rd_en;
  logic            sat_rd_valid;
  logic [KW-1:0]   sat_rd_key;
  logic [SDW-1:0]  sat_rd_dur;
  logic [AWID:0]   sat_count;
  logic            sat_full;
  logic            sat_overflow;
  logic            sat_busy;
  logic            sat_rec_en;
  logic            sat_clear;

  key_recorder #(.KEY_W(KW), .DUR_W(DW), .DEPTH(DEP), .AW(AWID)) dut (
    .clk(clk), .rst(rst), .key_on(key_on), .key(key), .rec_en(rec_en),
    .clear(clear), .rd_en(rd_en), .rd_valid(rd_valid), .rd_key(rd_key),
    .rd_dur(rd_dur), .count(count), .full(full), .overflow(overflow), .busy(busy)
  );

  // Narrow-duration instance for saturation behaviour
  key_recorder #(.KEY_W(KW), .DUR_W(SDW), .DEPTH(DEP), .AW(AWID)) dut_sat (
    .clk(clk), .rst(rst), .key_on(sat_key_on), .key(sat_key), .rec_en(sat_rec_en),
    .clear(sat_clear), .rd_en(sat_rd_en), .rd_valid(sat_rd_valid), .rd_key(sat_rd_key),
    .rd_dur(sat_rd_dur), .count(sat_count), .full(sat_full), .overflow(sat_overflow),
    .busy(sat_busy)
  );

  typedef struct {
    logic [KW-1:0] k;
    logic [DW-1:0] d;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   exp_count    = 0;
  bit   exp_overflow = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Reference model of FIFO admission: events beyond DEPTH are lost
  task automatic expectPush(input logic [KW-1:0] k, input logic [DW-1:0] d);
    exp_t e;
    if (exp_count < DEP) begin
      e.k = k;
      e.d = d;
      exp_q.push_back(e);
      exp_count++;
    end else begin
      exp_overflow = 1'b1;
    end
  endtask

  // Every popped event must match the oldest expected one
  always @(negedge clk) begin
    if (rst === 1'b1 && rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("pop_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("pop_key", 32'(rd_key), 32'(mon_e.k));
        checkOutput("pop_dur", 32'(rd_dur), 32'(mon_e.d));
        exp_count--;
      end
    end
  end

  // Plays one note for 'hold' sampled-high edges, then lets it commit
  task automatic applyStimulus(input logic [KW-1:0] k, input int hold);
    bit armed;
    @(negedge clk);
    key    = k;
    key_on = 1'b1;
    armed  = rec_en;
    @(negedge clk);
    checkOutput("busy_press", 32'(busy), 32'(armed));
    repeat (hold - 1) @(negedge clk);
    key_on = 1'b0;
    if (armed) expectPush(k, DW'(hold));
    repeat (2) @(negedge clk);
    checkOutput("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic popN(input int n);
    @(negedge clk);
    rd_en = 1'b1;
    repeat (n) @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulseClear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    exp_q.delete();
    exp_count    = 0;
    exp_overflow = 1'b0;
  endtask

  // Hard stop if the run ever stalls
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b0;
    key_on     = 1'b0;
    key        = '0;
    rec_en     = 1'b0;
    clear      = 1'b0;
    rd_en      = 1'b0;
    sat_key_on = 1'b0;
    sat_key    = '0;
    sat_rd_en  = 1'b0;
    sat_rec_en = 1'b1;
    sat_clear  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_rd_key",   32'(rd_key),   32'd0);
    checkOutput("rst_rd_dur",   32'(rd_dur),   32'd0);
    checkOutput("rst_count",    32'(count),    32'd0);
    checkOutput("rst_full",     32'(full),     32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_busy",     32'(busy),     32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single note, key 5 held 10 cycles
    rec_en = 1'b1;
    applyStimulus(NOTE_F, 10);
    checkOutput("t1_count_one", 32'(count), 32'd1);
    popN(1);
    checkOutput("t1_count_zero", 32'(count), 32'd0);

    // Legato: key 2 for 6 cycles straight into key 7 for 4 cycles
    @(negedge clk);
    key    = NOTE_D;
    key_on = 1'b1;
    repeat (6) @(negedge clk);
    key = NOTE_G;
    expectPush(NOTE_D, DW'(6));
    repeat (4) @(negedge clk);
    key_on = 1'b0;
    expectPush(NOTE_G, DW'(4));
    repeat (2) @(negedge clk);
    checkOutput("t2_count", 32'(count), 32'(exp_count));
    popN(2);
    checkOutput("t2_count_drained", 32'(count), 32'd0);

    // Pop request on an empty FIFO
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    checkOutput("t5_rdv_empty", 32'(rd_valid), 32'd0);
    rd_en = 1'b0;
    @(negedge clk);
    checkOutput("t5_rdv_after", 32'(rd_valid), 32'd0);
    checkOutput("t5_count", 32'(count), 32'd0);

    // Push and pop on the same edge at count 3
    applyStimulus(NOTE_C, 3);
    applyStimulus(NOTE_E, 4);
    applyStimulus(NOTE_A, 5);
    checkOutput("t7_count_three", 32'(count), 32'd3);
    @(negedge clk);
    key    = NOTE_B;
    key_on = 1'b1;
    repeat (3) @(negedge clk);
    key_on = 1'b0;
    expectPush(NOTE_B, DW'(3));
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    checkOutput("t7_count_same", 32'(count), 32'd3);
    popN(3);
    checkOutput("t7_count_drained", 32'(count), 32'd0);

    // Clear mid-press flushes stored events and the press in flight
    applyStimulus(NOTE_G, 3);
    checkOutput("t6_count_pre", 32'(count), 32'd1);
    @(negedge clk);
    key    = NOTE_DS;
    key_on = 1'b1;
    repeat (3) @(negedge clk);
    pulseClear();
    checkOutput("t6_count_clr", 32'(count), 32'd0);
    checkOutput("t6_busy_clr",  32'(busy),  32'd0);
    repeat (3) @(negedge clk);
    key_on = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("t6_count_post", 32'(count), 32'd0);
    popN(1);

    // rec_en dropping mid-press still commits; a disarmed press is ignored
    @(negedge clk);
    key    = NOTE_E;
    key_on = 1'b1;
    repeat (2) @(negedge clk);
    rec_en = 1'b0;
    repeat (3) @(negedge clk);
    key_on = 1'b0;
    expectPush(NOTE_E, DW'(5));
    repeat (2) @(negedge clk);
    checkOutput("recen_fall_count", 32'(count), 32'd1);
    applyStimulus(NOTE_A, 4);
    checkOutput("recen_off_count", 32'(count), 32'd1);
    popN(1);
    rec_en = 1'b1;

    // 33 presses overfill a 32-deep FIFO
    for (int i = 0; i < 33; i++) begin
      applyStimulus(KW'(i % 16), 2 + (i % 4));
    end
    checkOutput("t3_count",    32'(count),    32'(exp_count));
    checkOutput("t3_count32",  32'(count),    32'd32);
    checkOutput("t3_full",     32'(full),     32'd1);
    checkOutput("t3_overflow", 32'(overflow), 32'(exp_overflow));
    popN(32);
    checkOutput("t3_count_drained", 32'(count),    32'd0);
    checkOutput("t3_full_drained",  32'(full),     32'd0);
    checkOutput("t3_ovf_sticky",    32'(overflow), 32'd1);
    pulseClear();
    checkOutput("t3_ovf_cleared", 32'(overflow), 32'd0);

    // Asynchronous reset while a press is being timed
    applyStimulus(NOTE_A, 4);
    @(negedge clk);
    key    = NOTE_A;
    key_on = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("t8_busy_pre", 32'(busy), 32'd1);
    rst    = 1'b0;
    key_on = 1'b0;
    #1;
    checkOutput("t8_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("t8_rd_key",   32'(rd_key),   32'd0);
    checkOutput("t8_rd_dur",   32'(rd_dur),   32'd0);
    checkOutput("t8_count",    32'(count),    32'd0);
    checkOutput("t8_full",     32'(full),     32'd0);
    checkOutput("t8_overflow", 32'(overflow), 32'd0);
    checkOutput("t8_busy",     32'(busy),     32'd0);
    exp_q.delete();
    exp_count = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("t8_count_after", 32'(count), 32'd0);
    checkOutput("t8_busy_after",  32'(busy),  32'd0);

    // Saturation with a 4-bit duration: 20 cycles reads back as 15
    @(negedge clk);
    sat_key    = NOTE_D;
    sat_key_on = 1'b1;
    repeat (20) @(negedge clk);
    sat_key_on = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("t4_count", 32'(sat_count), 32'd1);
    sat_rd_en = 1'b1;
    @(negedge clk);
    sat_rd_en = 1'b0;
    checkOutput("t4_rd_valid", 32'(sat_rd_valid), 32'd1);
    checkOutput("t4_rd_key",   32'(sat_rd_key),   32'(NOTE_D));
    checkOutput("t4_rd_dur",   32'(sat_rd_dur),   32'd15);

    repeat (2) @(negedge clk);
    checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
